// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants, state encoding and the F/D register layout.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } fd_reg_t;

endpackage

// File: rtl/if_addr_check.sv
// Combinational AdEL detector: misaligned PC or PC outside the IM window.
module if_addr_check
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] i_pc,
    output logic        o_fault
);

    // 33-bit bound so a window ending at the top of the address space cannot wrap
    localparam logic [32:0] LAST = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4 - 33'd4;

    assign o_fault = (i_pc[1:0] != 2'b00) | (i_pc < IM_BASE) | ({1'b0, i_pc} > LAST);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: fetch PC, IM request/ready handshake, one-word skid
// buffer and F/D register. Optional AdEL checking under IF_ADDR_CHECK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc4,
    output logic        d_valid
`ifdef IF_ADDR_CHECK_EN
   ,output logic [4:0]  d_exc
`endif
);

    fetch_state_e r_state;
    logic         r_run;
    logic [31:0]  r_pc;
    logic [31:0]  r_buf;
    fd_reg_t      r_fd;
    logic         w_fault;
    logic         w_fetch;
    logic [31:0]  w_pc4;

    if (IM_BASE[1:0] != 2'b00 || IM_WORDS < 1) begin : g_bad_cfg
        $error("if_fetch: IM_BASE must be word aligned and IM_WORDS positive");
    end

    // r_run keeps im_req low until the first edge after reset is released
    assign w_fetch = r_run & (r_state == FETCH);
    assign w_pc4   = r_pc + 32'd4;
    assign im_req  = w_fetch & ~w_fault;
    assign im_addr = r_pc;
    assign pc      = r_pc;
    assign d_instr = r_fd.instr;
    assign d_pc    = r_fd.pc;
    assign d_pc4   = r_fd.pc4;
    assign d_valid = r_fd.valid;

`ifdef IF_ADDR_CHECK_EN
    logic [4:0] r_exc;

    if_addr_check #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_addr_check (
        .i_pc    (r_pc),
        .o_fault (w_fault)
    );

    assign d_exc = r_exc;
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
            r_buf   <= '0;
            r_fd    <= '0;
`ifdef IF_ADDR_CHECK_EN
            r_exc   <= '0;
`endif
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                // Redirect wins: the outstanding request and any buffered word are dropped
                r_fd.instr <= '0;
                r_fd.valid <= 1'b0;
                r_pc       <= npc;
                r_buf      <= '0;
                r_state    <= FETCH;
`ifdef IF_ADDR_CHECK_EN
                r_exc      <= '0;
`endif
            end else if (r_state == HOLD) begin
                if (!stall) begin
                    r_fd    <= '{instr: r_buf, pc: r_pc, pc4: w_pc4, valid: 1'b1};
                    r_pc    <= npc;
                    r_state <= FETCH;
`ifdef IF_ADDR_CHECK_EN
                    r_exc   <= '0;
`endif
                end
            end else if (r_run) begin
                if (w_fault) begin
                    if (!stall) begin
                        r_fd  <= '{instr: 32'd0, pc: r_pc, pc4: w_pc4, valid: 1'b1};
                        r_pc  <= npc;
`ifdef IF_ADDR_CHECK_EN
                        r_exc <= EXC_ADEL;
`endif
                    end
                end else if (im_ready && !stall) begin
                    r_fd  <= '{instr: im_rdata, pc: r_pc, pc4: w_pc4, valid: 1'b1};
                    r_pc  <= npc;
`ifdef IF_ADDR_CHECK_EN
                    r_exc <= '0;
`endif
                end else if (im_ready) begin
                    r_buf   <= im_rdata;
                    r_state <= HOLD;
                end else if (!stall) begin
                    r_fd.instr <= '0;
                    r_fd.valid <= 1'b0;
`ifdef IF_ADDR_CHECK_EN
                    r_exc      <= '0;
`endif
                end
            end
        end
    end

endmodule
